// File: rtl/o2k_resp_pkg.sv
// Shared AXI constants, FSM state types and the burst legality check used by o2k_mem_responder.
package o2k_resp_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [2:0] AXI_SIZE_16B    = 3'd4;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

   // Illegal when the last beat lands at or past the end of RAM, or the burst is not 16 B INCR.
   function automatic logic burst_err(input logic [59:0]  word_addr,
                                      input logic [1:0]   burst,
                                      input logic [2:0]   size,
                                      input logic [7:0]   len,
                                      input int unsigned  mem_addr_width);
      logic [63:0] last_idx;
      last_idx = {4'd0, word_addr} + {56'd0, len};
      return (last_idx >= (64'd1 << mem_addr_width)) ||
             (burst != AXI_BURST_INCR) ||
             (size != AXI_SIZE_16B);
   endfunction

endpackage

// File: rtl/o2k_resp_ram.sv
// Simple dual-port 128-bit RAM: byte-enabled write on port A, registered read on port B.
// Read-first on same-index collisions; contents are never reset.
module o2k_resp_ram #(
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic [15:0]               we_a,
   input  logic [MEM_ADDR_WIDTH-1:0] addr_a,
   input  logic [127:0]              din_a,
   input  logic                      rd_en_b,
   input  logic [MEM_ADDR_WIDTH-1:0] addr_b,
   output logic [127:0]              dout_b
);

   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

   logic [127:0] mem [DEPTH];
   logic [127:0] rd_data_q;

   // Both ports update in one block so a colliding read samples the pre-write word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (we_a[i]) begin
            mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
         end
      end
      if (rd_en_b) begin
         rd_data_q <= mem[addr_b];
      end
   end

   assign dout_b = rd_data_q;

endmodule

// File: rtl/o2k_mem_responder.sv
// AXI4 slave answering the o2k request stream from on-chip RAM with independent write/read FSMs.
// Define O2K_RESP_ERR_EN to flag out-of-range, non-INCR or non-16B bursts with SLVERR.
module o2k_mem_responder
   import o2k_resp_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int ID_WIDTH       = 4
) (
   input  logic                clk,
   input  logic                rstn,

   input  logic [63:0]         o2k_awaddr,
   input  logic [1:0]          o2k_awburst,
   input  logic [ID_WIDTH-1:0] o2k_awid,
   input  logic [7:0]          o2k_awlen,
   input  logic [2:0]          o2k_awsize,
   input  logic                o2k_awvalid,
   output logic                o2k_awready,

   input  logic [127:0]        o2k_wdata,
   input  logic [15:0]         o2k_wstrb,
   input  logic                o2k_wlast,
   input  logic                o2k_wvalid,
   output logic                o2k_wready,

   output logic [ID_WIDTH-1:0] o2k_bid,
   output logic [1:0]          o2k_bresp,
   output logic                o2k_bvalid,
   input  logic                o2k_bready,

   input  logic [63:0]         o2k_araddr,
   input  logic [1:0]          o2k_arburst,
   input  logic [ID_WIDTH-1:0] o2k_arid,
   input  logic [7:0]          o2k_arlen,
   input  logic [2:0]          o2k_arsize,
   input  logic                o2k_arvalid,
   output logic                o2k_arready,

   output logic [127:0]        o2k_rdata,
   output logic [ID_WIDTH-1:0] o2k_rid,
   output logic [1:0]          o2k_rresp,
   output logic                o2k_rlast,
   output logic                o2k_rvalid,
   input  logic                o2k_rready
);

   localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE = MEM_ADDR_WIDTH'(1);

   w_state_t                  w_state_q, w_state_d;
   logic                      awready_q, awready_d;
   logic [ID_WIDTH-1:0]       w_id_q, w_id_d;
   logic [7:0]                w_len_q, w_len_d;
   logic [7:0]                w_cnt_q, w_cnt_d;
   logic [MEM_ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
   logic [1:0]                w_resp_q, w_resp_d;

   r_state_t                  r_state_q, r_state_d;
   logic                      arready_q, arready_d;
   logic [ID_WIDTH-1:0]       r_id_q, r_id_d;
   logic [7:0]                r_len_q, r_len_d;
   logic [7:0]                r_cnt_q, r_cnt_d;
   logic [MEM_ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
   logic [1:0]                r_resp_q, r_resp_d;

   logic [15:0]               ram_we;
   logic                      ram_rd_en;
   logic [127:0]              ram_rdata;
   logic                      aw_err;
   logic                      ar_err;
   logic                      unused_inputs;

`ifdef O2K_RESP_ERR_EN
   assign aw_err = burst_err(o2k_awaddr[63:4], o2k_awburst, o2k_awsize, o2k_awlen, MEM_ADDR_WIDTH);
   assign ar_err = burst_err(o2k_araddr[63:4], o2k_arburst, o2k_arsize, o2k_arlen, MEM_ADDR_WIDTH);
`else
   assign aw_err = 1'b0;
   assign ar_err = 1'b0;
`endif

   // wlast and the attributes below only matter to the error check, if at all.
   assign unused_inputs = ^{o2k_wlast, o2k_awaddr, o2k_awburst, o2k_awsize,
                            o2k_araddr, o2k_arburst, o2k_arsize};

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_idx_d   = w_idx_q;
      w_resp_d  = w_resp_q;
      ram_we    = '0;
      unique case (w_state_q)
         W_IDLE: begin
            if (o2k_awvalid && awready_q) begin
               w_id_d    = o2k_awid;
               w_len_d   = o2k_awlen;
               w_idx_d   = o2k_awaddr[4 +: MEM_ADDR_WIDTH];
               w_cnt_d   = '0;
               w_resp_d  = aw_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (o2k_wvalid) begin
               ram_we  = (w_resp_q == AXI_RESP_OKAY) ? o2k_wstrb : 16'h0000;
               w_idx_d = w_idx_q + IDX_ONE;
               w_cnt_d = w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) begin
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (o2k_bready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_idx_q   <= '0;
         w_resp_q  <= AXI_RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_idx_q   <= w_idx_d;
         w_resp_q  <= w_resp_d;
      end
   end

   // Each beat costs a FETCH cycle for the RAM read, then a SEND cycle holding it.
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_idx_d   = r_idx_q;
      r_resp_d  = r_resp_q;
      ram_rd_en = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (o2k_arvalid && arready_q) begin
               r_id_d    = o2k_arid;
               r_len_d   = o2k_arlen;
               r_idx_d   = o2k_araddr[4 +: MEM_ADDR_WIDTH];
               r_cnt_d   = '0;
               r_resp_d  = ar_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            ram_rd_en = 1'b1;
            r_state_d = R_SEND;
         end
         R_SEND: begin
            if (o2k_rready) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_idx_d   = r_idx_q + IDX_ONE;
                  r_cnt_d   = r_cnt_q + 8'd1;
                  r_state_d = R_FETCH;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_idx_q   <= '0;
         r_resp_q  <= AXI_RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_idx_q   <= r_idx_d;
         r_resp_q  <= r_resp_d;
      end
   end

   o2k_resp_ram #(
      .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .we_a    (ram_we),
      .addr_a  (w_idx_q),
      .din_a   (o2k_wdata),
      .rd_en_b (ram_rd_en),
      .addr_b  (r_idx_q),
      .dout_b  (ram_rdata)
   );

   assign o2k_awready = awready_q;
   assign o2k_wready  = (w_state_q == W_DATA);
   assign o2k_bvalid  = (w_state_q == W_RESP);
   assign o2k_bid     = w_id_q;
   assign o2k_bresp   = w_resp_q;

   // The RAM has no reset, so rdata is gated to zero outside SEND and for erroring bursts.
   assign o2k_arready = arready_q;
   assign o2k_rvalid  = (r_state_q == R_SEND);
   assign o2k_rlast   = (r_state_q == R_SEND) && (r_cnt_q == r_len_q);
   assign o2k_rdata   = ((r_state_q == R_SEND) && (r_resp_q == AXI_RESP_OKAY)) ? ram_rdata : '0;
   assign o2k_rid     = r_id_q;
   assign o2k_rresp   = r_resp_q;

endmodule

// File: tb/tb_o2k_mem_responder.sv
// Self-checking bench for o2k_mem_responder: directed table, multi-beat corner cases and
// random bursts checked against a word-array memory model.
module tb_o2k_mem_responder;

   localparam int MAW   = 10;
   localparam int IDW   = 4;
   localparam int DEPTH = 1 << MAW;

   logic           clk = 1'b0;
   logic           rstn;
   logic [63:0]    o2k_awaddr;
   logic [1:0]     o2k_awburst;
   logic [IDW-1:0] o2k_awid;
   logic [7:0]     o2k_awlen;
   logic [2:0]     o2k_awsize;
   logic           o2k_awvalid;
   logic           o2k_awready;
   logic [127:0]   o2k_wdata;
   logic [15:0]    o2k_wstrb;
   logic           o2k_wlast;
   logic           o2k_wvalid;
   logic           o2k_wready;
   logic [IDW-1:0] o2k_bid;
   logic [1:0]     o2k_bresp;
   logic           o2k_bvalid;
   logic           o2k_bready;
   logic [63:0]    o2k_araddr;
   logic [1:0]     o2k_arburst;
   logic [IDW-1:0] o2k_arid;
   logic [7:0]     o2k_arlen;
   logic [2:0]     o2k_arsize;
   logic           o2k_arvalid;
   logic           o2k_arready;
   logic [127:0]   o2k_rdata;
   logic [IDW-1:0] o2k_rid;
   logic [1:0]     o2k_rresp;
   logic           o2k_rlast;
   logic           o2k_rvalid;
   logic           o2k_rready;

   always #5 clk = ~clk;

   o2k_mem_responder #(
      .MEM_ADDR_WIDTH (MAW),
      .ID_WIDTH       (IDW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .o2k_awaddr  (o2k_awaddr),
      .o2k_awburst (o2k_awburst),
      .o2k_awid    (o2k_awid),
      .o2k_awlen   (o2k_awlen),
      .o2k_awsize  (o2k_awsize),
      .o2k_awvalid (o2k_awvalid),
      .o2k_awready (o2k_awready),
      .o2k_wdata   (o2k_wdata),
      .o2k_wstrb   (o2k_wstrb),
      .o2k_wlast   (o2k_wlast),
      .o2k_wvalid  (o2k_wvalid),
      .o2k_wready  (o2k_wready),
      .o2k_bid     (o2k_bid),
      .o2k_bresp   (o2k_bresp),
      .o2k_bvalid  (o2k_bvalid),
      .o2k_bready  (o2k_bready),
      .o2k_araddr  (o2k_araddr),
      .o2k_arburst (o2k_arburst),
      .o2k_arid    (o2k_arid),
      .o2k_arlen   (o2k_arlen),
      .o2k_arsize  (o2k_arsize),
      .o2k_arvalid (o2k_arvalid),
      .o2k_arready (o2k_arready),
      .o2k_rdata   (o2k_rdata),
      .o2k_rid     (o2k_rid),
      .o2k_rresp   (o2k_rresp),
      .o2k_rlast   (o2k_rlast),
      .o2k_rvalid  (o2k_rvalid),
      .o2k_rready  (o2k_rready)
   );

   int           total = 0;
   int           bad   = 0;
   logic [127:0] memModel [DEPTH];
   logic [127:0] beatData [256];
   logic [15:0]  beatStrb [256];
   logic [127:0] readData [256];

   typedef struct {
      bit           isWrite;
      logic [63:0]  addr;
      logic [3:0]   id;
      logic [127:0] data;
      logic [15:0]  strb;
      logic [127:0] expData;
      logic [1:0]   expResp;
   } vec_t;

   vec_t vecs [6];

   // Advance to just after the next rising edge, where inputs are driven and outputs sampled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got no handshake within bound, required one", name);
   endtask

   // A burst errors only when error responses are built in and it runs past the last word.
   function automatic logic modelErr(input logic [63:0] addr, input int len);
      logic err;
      err = (((addr >> 4) + 64'(len)) >= 64'(DEPTH));
`ifndef O2K_RESP_ERR_EN
      err = 1'b0;
`endif
      return err;
   endfunction

   function automatic int modelIdx(input logic [63:0] addr, input int beat);
      return int'(((addr >> 4) + 64'(beat)) % 64'(DEPTH));
   endfunction

   task automatic modelWrite(input int idx, input logic [127:0] data, input logic [15:0] strb);
      for (int b = 0; b < 16; b++) begin
         if (strb[b]) memModel[idx][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   // Full write transaction; beats come from beatData/beatStrb, bready is held low for bDelay cycles.
   task automatic axiWrite(input logic [63:0] addr, input logic [3:0] id, input int len,
                           input int bDelay, input int gapMax, input logic [1:0] expResp);
      int cnt;
      o2k_awaddr  = addr;
      o2k_awid    = id;
      o2k_awlen   = 8'(len);
      o2k_awburst = 2'b01;
      o2k_awsize  = 3'd4;
      o2k_awvalid = 1'b1;
      cnt = 0;
      while (!o2k_awready && cnt < 20) begin step(); cnt++; end
      if (!o2k_awready) begin timeoutFail("aw_handshake"); o2k_awvalid = 1'b0; return; end
      step();
      o2k_awvalid = 1'b0;
      checkOutput("wready_after_aw", 128'({o2k_wready, o2k_awready}), 128'(2'b10));
      for (int i = 0; i <= len; i++) begin
         repeat ($urandom_range(0, gapMax)) step();
         o2k_wdata  = beatData[i];
         o2k_wstrb  = beatStrb[i];
         o2k_wlast  = (i == len);
         o2k_wvalid = 1'b1;
         cnt = 0;
         while (!o2k_wready && cnt < 20) begin step(); cnt++; end
         if (!o2k_wready) begin timeoutFail("w_handshake"); o2k_wvalid = 1'b0; return; end
         step();
         o2k_wvalid = 1'b0;
      end
      checkOutput("bvalid_after_last_w", 128'({o2k_bvalid, o2k_wready}), 128'(2'b10));
      for (int c = 0; c < bDelay; c++) begin
         step();
         checkOutput("b_hold", 128'({o2k_bvalid, o2k_awready, o2k_bid, o2k_bresp}),
                     128'({1'b1, 1'b0, id, expResp}));
      end
      checkOutput("bid_bresp", 128'({o2k_bid, o2k_bresp}), 128'({id, expResp}));
      o2k_bready = 1'b1;
      step();
      o2k_bready = 1'b0;
      checkOutput("awready_after_b", 128'({o2k_awready, o2k_bvalid}), 128'(2'b10));
      if (expResp == 2'b00) begin
         for (int i = 0; i <= len; i++) modelWrite(modelIdx(addr, i), beatData[i], beatStrb[i]);
      end
   endtask

   // Full read transaction; each beat is left pending with rready low for `hold` cycles.
   task automatic axiRead(input logic [63:0] addr, input logic [3:0] id, input int len, input int hold);
      int           cnt;
      logic         err;
      logic [127:0] expData;
      err = modelErr(addr, len);
      o2k_araddr  = addr;
      o2k_arid    = id;
      o2k_arlen   = 8'(len);
      o2k_arburst = 2'b01;
      o2k_arsize  = 3'd4;
      o2k_arvalid = 1'b1;
      cnt = 0;
      while (!o2k_arready && cnt < 20) begin step(); cnt++; end
      if (!o2k_arready) begin timeoutFail("ar_handshake"); o2k_arvalid = 1'b0; return; end
      step();
      o2k_arvalid = 1'b0;
      for (int beat = 0; beat <= len; beat++) begin
         cnt = 0;
         while (!o2k_rvalid && cnt < 20) begin step(); cnt++; end
         if (!o2k_rvalid) begin timeoutFail("r_valid"); return; end
         checkOutput("r_latency", 128'(cnt), 128'(1));
         expData = err ? 128'd0 : memModel[modelIdx(addr, beat)];
         checkOutput("rdata", o2k_rdata, expData);
         checkOutput("rid_rresp_rlast", 128'({o2k_rid, o2k_rresp, o2k_rlast}),
                     128'({id, (err ? 2'b10 : 2'b00), (beat == len)}));
         readData[beat] = o2k_rdata;
         for (int h = 0; h < hold; h++) begin
            step();
            checkOutput("r_hold_data", o2k_rdata, expData);
            checkOutput("r_hold_ctl", 128'({o2k_rvalid, o2k_arready, o2k_rlast}),
                        128'({1'b1, 1'b0, (beat == len)}));
         end
         o2k_rready = 1'b1;
         step();
         o2k_rready = 1'b0;
      end
      checkOutput("arready_after_last_r", 128'({o2k_arready, o2k_rvalid}), 128'(2'b10));
   endtask

   // Runs the single-beat table; read entries also compare against their listed data.
   task automatic applyStimulus();
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].isWrite) begin
            beatData[0] = vecs[v].data;
            beatStrb[0] = vecs[v].strb;
            axiWrite(vecs[v].addr, vecs[v].id, 0, 0, 0, vecs[v].expResp);
         end else begin
            axiRead(vecs[v].addr, vecs[v].id, 0, 0);
            checkOutput($sformatf("vec%0d_rdata", v), readData[0], vecs[v].expData);
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no end of test, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] preLast, preFirst, wrapA, wrapB, keep0, keep1;
      logic [63:0]  addr;
      int           len;

      vecs[0] = '{1'b1, 64'h100, 4'd3, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 128'd0, 2'b00};
      vecs[1] = '{1'b0, 64'h100, 4'd5, 128'd0, 16'h0000, 128'h0123456789ABCDEF0123456789ABCDEF, 2'b00};
      vecs[2] = '{1'b1, 64'h200, 4'd1, {128{1'b1}}, 16'hFFFF, 128'd0, 2'b00};
      vecs[3] = '{1'b1, 64'h200, 4'd2, 128'd0, 16'h0001, 128'd0, 2'b00};
      vecs[4] = '{1'b0, 64'h200, 4'd6, 128'd0, 16'h0000, {{120{1'b1}}, 8'h00}, 2'b00};
      vecs[5] = '{1'b0, 64'h100, 4'hF, 128'd0, 16'h0000, 128'h0123456789ABCDEF0123456789ABCDEF, 2'b00};

      rstn = 1'b0;
      o2k_awaddr = '0; o2k_awburst = 2'b01; o2k_awid = '0; o2k_awlen = '0; o2k_awsize = 3'd4; o2k_awvalid = 1'b0;
      o2k_wdata = '0; o2k_wstrb = '0; o2k_wlast = 1'b0; o2k_wvalid = 1'b0; o2k_bready = 1'b0;
      o2k_araddr = '0; o2k_arburst = 2'b01; o2k_arid = '0; o2k_arlen = '0; o2k_arsize = 3'd4; o2k_arvalid = 1'b0;
      o2k_rready = 1'b0;
      for (int i = 0; i < DEPTH; i++) memModel[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ctl", 128'({o2k_awready, o2k_arready, o2k_wready, o2k_bvalid, o2k_rvalid, o2k_rlast}), 128'd0);
      checkOutput("reset_ids", 128'({o2k_bid, o2k_bresp, o2k_rid, o2k_rresp}), 128'd0);
      checkOutput("reset_rdata", o2k_rdata, 128'd0);
      rstn = 1'b1;
      checkOutput("ready_before_edge", 128'({o2k_awready, o2k_arready}), 128'd0);
      step();
      checkOutput("ready_after_edge", 128'({o2k_awready, o2k_arready}), 128'(2'b11));

      $display("[TB] filling words 0..63");
      for (int i = 0; i < 64; i++) begin
         beatData[i] = {$urandom, $urandom, $urandom, $urandom};
         beatStrb[i] = 16'hFFFF;
      end
      axiWrite(64'h0, 4'h0, 63, 0, 0, 2'b00);

      applyStimulus();

      $display("[TB] 4-beat burst");
      for (int i = 0; i < 4; i++) begin
         beatData[i] = 128'(i + 1);
         beatStrb[i] = 16'hFFFF;
      end
      axiWrite(64'h0, 4'h9, 3, 0, 0, 2'b00);
      axiRead(64'h0, 4'hA, 3, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("burst4_beat%0d", i), readData[i], 128'(i + 1));

      $display("[TB] wrap at last word");
      preLast  = 128'hDEADBEEF_00000000_11111111_22222222;
      preFirst = 128'hCAFEF00D_33333333_44444444_55555555;
      wrapA    = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
      wrapB    = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;
      beatData[0] = preLast;  beatStrb[0] = 16'hFFFF;
      axiWrite(64'h3FF0, 4'h1, 0, 0, 0, 2'b00);
      beatData[0] = preFirst; beatStrb[0] = 16'hFFFF;
      axiWrite(64'h0, 4'h1, 0, 0, 0, 2'b00);
      beatData[0] = wrapA; beatStrb[0] = 16'hFFFF;
      beatData[1] = wrapB; beatStrb[1] = 16'hFFFF;
`ifdef O2K_RESP_ERR_EN
      axiWrite(64'h3FF0, 4'h2, 1, 0, 0, 2'b10);
      axiRead(64'h3FF0, 4'h3, 0, 0);
      checkOutput("wrap_last_word", readData[0], preLast);
      axiRead(64'h0, 4'h3, 0, 0);
      checkOutput("wrap_first_word", readData[0], preFirst);
`else
      axiWrite(64'h3FF0, 4'h2, 1, 0, 0, 2'b00);
      axiRead(64'h3FF0, 4'h3, 0, 0);
      checkOutput("wrap_last_word", readData[0], wrapA);
      axiRead(64'h0, 4'h3, 0, 0);
      checkOutput("wrap_first_word", readData[0], wrapB);
`endif
      axiRead(64'h3FF0, 4'h4, 1, 0);

      $display("[TB] backpressure");
      for (int i = 0; i < 3; i++) begin
         beatData[i] = {$urandom, $urandom, $urandom, $urandom};
         beatStrb[i] = 16'hFFFF;
      end
      axiWrite(64'h500, 4'h5, 2, 5, 1, 2'b00);
      axiRead(64'h500, 4'h6, 2, 1);

      $display("[TB] reset during 8-beat write");
      keep0 = {$urandom, $urandom, $urandom, $urandom};
      keep1 = {$urandom, $urandom, $urandom, $urandom};
      o2k_awaddr = 64'h400; o2k_awid = 4'h7; o2k_awlen = 8'd7; o2k_awvalid = 1'b1;
      step();
      step();
      o2k_awvalid = 1'b0;
      checkOutput("rst_burst_wready", 128'(o2k_wready), 128'd1);
      o2k_wstrb = 16'hFFFF; o2k_wvalid = 1'b1;
      o2k_wdata = keep0;
      step();
      o2k_wdata = keep1;
      step();
      o2k_wvalid = 1'b0;
      rstn = 1'b0;
      #1;
      checkOutput("rst_mid_ctl", 128'({o2k_awready, o2k_arready, o2k_wready, o2k_bvalid, o2k_rvalid, o2k_rlast}), 128'd0);
      checkOutput("rst_mid_ids", 128'({o2k_bid, o2k_bresp, o2k_rid, o2k_rresp}), 128'd0);
      checkOutput("rst_mid_rdata", o2k_rdata, 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      modelWrite(64, keep0, 16'hFFFF);
      modelWrite(65, keep1, 16'hFFFF);
      for (int c = 0; c < 4; c++) begin
         step();
         checkOutput("no_b_after_reset", 128'({o2k_bvalid, o2k_wready}), 128'd0);
      end
      axiRead(64'h400, 4'h8, 1, 0);
      checkOutput("rst_kept_word0", readData[0], keep0);
      checkOutput("rst_kept_word1", readData[1], keep1);

      $display("[TB] random bursts");
      for (int n = 0; n < 24; n++) begin
         len  = int'($urandom_range(0, 7));
         addr = (64'($urandom_range(0, 63 - len)) << 4) | 64'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= len; i++) begin
               beatData[i] = {$urandom, $urandom, $urandom, $urandom};
               beatStrb[i] = 16'($urandom);
            end
            axiWrite(addr, 4'($urandom), len, int'($urandom_range(0, 3)), 1,
                     modelErr(addr, len) ? 2'b10 : 2'b00);
         end else begin
            axiRead(addr, 4'($urandom), len, int'($urandom_range(0, 2)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/o2k_mem_responder.md
# o2k_mem_responder

AXI4 memory-mapped slave that answers the oculink-to-kernel (o2k) request stream with real write and read data. It replaces the buffer-only o2k path with a burst-capable responder backed by on-chip RAM. It accepts AW/W/AR, writes or reads RAM beat by beat, and returns B/R responses with the request ID. It sits between the oculink AXI master and the kernel's internal storage.

## Interface
- MEM_ADDR_WIDTH, 10, log2 of RAM depth in 128-bit words; RAM index is addr[4 +: MEM_ADDR_WIDTH]
- ID_WIDTH, 4, AXI ID width
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- o2k_aw{addr,burst,id,len,size,valid}  in  64/2/ID_WIDTH/8/3/1  write address channel
- o2k_awready  out  1  write address accepted
- o2k_w{data,strb,last,valid}  in  128/16/1/1  write data channel
- o2k_wready  out  1
- o2k_b{id,resp,valid}  out  ID_WIDTH/2/1  write response
- o2k_bready  in  1
- o2k_ar{addr,burst,id,len,size,valid}  in  64/2/ID_WIDTH/8/3/1  read address channel
- o2k_arready  out  1
- o2k_r{data,id,resp,last,valid}  out  128/ID_WIDTH/2/1/1  read data
- o2k_rready  in  1
- The remaining AXI attributes (cache, lock, prot, qos, region) are not ports of this block and are ignored upstream.

## Operation
- Write and read paths are independent FSMs sharing one dual-port RAM: write port A, read port B, byte write enables, 1-cycle read latency.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On an AW handshake, latch id, len, and the start index; beat counter = 0.
  - W_DATA: wready=1. Each W handshake writes wdata under wstrb to the current index, then index+1 and counter+1. The beat with counter==len moves to W_RESP.
  - wlast is ignored. The beat count alone terminates the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=latched status. On bready, go to W_IDLE.
- Read FSM R_IDLE -> R_FETCH -> R_SEND:
  - R_IDLE: arready=1. On an AR handshake, latch id, len, and index.
  - R_FETCH: drive the RAM read at the current index.
  - R_SEND: rvalid=1, rdata=RAM output held in a register, rid=latched id, rlast=(counter==len).
  - On rready in R_SEND: if last, go to R_IDLE; otherwise index+1, counter+1, and go to R_FETCH.
- Index arithmetic is MEM_ADDR_WIDTH bits wide and wraps modulo the RAM depth. addr[3:0] is ignored. Every beat is 16 B INCR.
- Simultaneous read and write to the same index in the same cycle: the read returns the old data (read-first).
- RAM contents are not cleared by reset.

## Timing
- Reset: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, and all data/id/resp outputs are 0. Both FSMs are in IDLE.
- awready and arready are registered. They rise in the first clk edge after rstn deasserts.
- Write: AW handshake at cycle T. wready=1 from T+1. The final W beat at cycle U gives bvalid=1 at U+1. The B handshake at V gives awready=1 at V+1.
- Read: AR handshake at T. rvalid=1 at T+2. After each non-last R handshake, the next beat is valid 2 cycles later. Throughput is 1 beat per 2 cycles.
- After the last R handshake at V, arready=1 at V+1.
- Valid outputs, once raised, stay high with stable payload until their handshake completes.
- Reset asserted mid-burst: the burst is abandoned, all outputs return to reset values immediately (asynchronous), and no B or R response is issued for that burst.

## Configuration
- O2K_RESP_ERR_EN defined:
  - A burst is marked SLVERR (2'b10) if addr[63:4] exceeds the RAM depth, if the burst crosses the end of RAM, if burst!=INCR (1), or if size!=4.
  - For an erroring write, all beats are accepted, RAM writes are suppressed, and bresp=SLVERR.
  - For an erroring read, the full len+1 beats are returned with rdata=0 and rresp=SLVERR.
- O2K_RESP_ERR_EN undefined: burst, size and upper address bits are ignored, the index wraps, and bresp/rresp are always OKAY (2'b00).

## Structure
- Package o2k_resp_pkg holds:
  - constants AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_SIZE_16B=3'd4
  - enums w_state_t {W_IDLE, W_DATA, W_RESP} and r_state_t {R_IDLE, R_FETCH, R_SEND}
- Sub-module o2k_resp_ram: simple dual-port RAM, 128-bit, 16 byte enables, read-first, 1-cycle read, parameter MEM_ADDR_WIDTH, no reset.

## Test plan
- Single write, addr 0x100, len 0, data 0x0123…EF, strb all ones, bid=3. Then read addr 0x100, id=5. Required: bresp=OKAY, bid=3; one R beat with the same data, rid=5, rlast=1, rvalid at T+2.
- 4-beat burst write at 0x0 with data 1..4, then a 4-beat read. Required: data 1,2,3,4, with rlast only on the 4th beat.
- Partial strobe: write 0xFF..FF to word 0x20, then strb=16'h0001 with data 0. Required: read returns 0xFF..FF00.
- Wrap, MEM_ADDR_WIDTH=4: 2-beat write at index 15.
  - ERR_EN undefined: words 15 then 0 are written, resp OKAY.
  - ERR_EN defined: bresp=SLVERR and the RAM is unchanged.
- Backpressure: bready low for 5 cycles and rready toggling every cycle. Required: bvalid/rvalid and their payloads are held stable, and awready/arready stay 0 until the response handshake completes.
- Reset asserted after the 2nd beat of an 8-beat write. Required: outputs go to reset values with no bvalid; a later read of the first 2 words returns the written data.
